// File: rtl/sram_chip_model.sv
// Clocked stand-in for the 16-bit external asynchronous SRAM: strobe-sampled writes
// and a fixed-latency, fully pipelined read path that survives nothing but the array.
module sram_chip_model #(
  parameter int ADDR_W   = 16,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sram_ce_n,
  input  logic              sram_we_n,
  input  logic              sram_oe_n,
  input  logic [ADDR_W-1:0] sram_addr,
  input  logic [15:0]       sram_din,
  output logic [15:0]       sram_dout,
  output logic              dout_en,
  output logic              busy,
  output logic              conflict
);

  localparam int DEPTH = 2 ** ADDR_W;

  generate
    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
      $error("sram_chip_model: READ_LAT must be in 1..4");
    end
  endgenerate

  logic [15:0] mem [DEPTH];

  logic                wr_en;
  logic                rd_issue;
  logic                conflict_hit;
  logic [READ_LAT-1:0] valid_reg;
  logic [READ_LAT-1:0] valid_next;
  logic [15:0]         data_reg [READ_LAT];
  logic                conflict_reg;

  // A write always wins over output enable; a read is only issued with we_n high.
  assign wr_en        = ~sram_ce_n & ~sram_we_n;
  assign rd_issue     = ~sram_ce_n & sram_we_n & ~sram_oe_n;
  assign conflict_hit = wr_en & ~sram_oe_n;

  // Deselect flushes every stage; otherwise valid bits simply shift.
  assign valid_next[0] = rd_issue;
  genvar gi;
  generate
    for (gi = 1; gi < READ_LAT; gi++) begin : g_stage_valid
      assign valid_next[gi] = ~sram_ce_n & valid_reg[gi-1];
    end
  endgenerate

  // Array has no reset so its contents survive reset_n.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[sram_addr] <= sram_din;
    end
  end

  // Data only advances alongside a valid bit, so the output stage holds the last returned word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg    <= '0;
      conflict_reg <= 1'b0;
      for (int k = 0; k < READ_LAT; k++) begin
        data_reg[k] <= 16'h0000;
      end
    end else begin
      valid_reg    <= valid_next;
      conflict_reg <= conflict_hit;
      if (rd_issue) begin
        data_reg[0] <= mem[sram_addr];
      end
      for (int k = 1; k < READ_LAT; k++) begin
        if (valid_next[k]) begin
          data_reg[k] <= data_reg[k-1];
        end
      end
    end
  end

  assign sram_dout = data_reg[READ_LAT-1];
  assign dout_en   = valid_reg[READ_LAT-1] & ~sram_oe_n & ~sram_ce_n;
  assign busy      = |valid_reg;
  assign conflict  = conflict_reg;

endmodule

// File: tb/tb_sram_chip_model.sv
// Directed bench: a READ_LAT=2 device checked against a vector table, plus a READ_LAT=3 device
// sharing the same pins for latency and flush corner cases.
module tb_sram_chip_model;

  logic        clk;
  logic        reset_n;
  logic        sram_ce_n, sram_we_n, sram_oe_n;
  logic [15:0] sram_addr, sram_din;
  logic [15:0] dout2, dout3;
  logic        en2, en3, busy2, busy3, conf2, conf3;

  int checks = 0;
  int errors = 0;

  sram_chip_model #(.ADDR_W(16), .READ_LAT(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n),
    .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .sram_addr(sram_addr), .sram_din(sram_din),
    .sram_dout(dout2), .dout_en(en2), .busy(busy2), .conflict(conf2)
  );

  sram_chip_model #(.ADDR_W(16), .READ_LAT(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n),
    .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .sram_addr(sram_addr), .sram_din(sram_din),
    .sram_dout(dout3), .dout_en(en3), .busy(busy3), .conflict(conf3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ce_n, we_n, oe_n;
    logic [15:0] addr, din;
    logic        en;
    logic [15:0] dout;
    logic        busy, conf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive pins at the falling edge, let one rising edge consume them, then settle before checks.
  task automatic step(input logic ce_n, input logic we_n, input logic oe_n,
                      input logic [15:0] addr, input logic [15:0] din);
    @(negedge clk);
    sram_ce_n = ce_n;
    sram_we_n = we_n;
    sram_oe_n = oe_n;
    sram_addr = addr;
    sram_din  = din;
    @(posedge clk);
    #1;
  endtask

  task automatic chk2(input string tag, input logic en, input logic [15:0] dout,
                      input logic busy, input logic conf);
    chk({tag, " en2"},   {15'd0, en2},   {15'd0, en});
    chk({tag, " dout2"}, dout2,          dout);
    chk({tag, " busy2"}, {15'd0, busy2}, {15'd0, busy});
    chk({tag, " conf2"}, {15'd0, conf2}, {15'd0, conf});
    $display("%s: ce_n=%b we_n=%b oe_n=%b addr=%h din=%h -> en=%b dout=%h busy=%b conf=%b",
             tag, sram_ce_n, sram_we_n, sram_oe_n, sram_addr, sram_din, en2, dout2, busy2, conf2);
  endtask

  initial begin
    //              ce we oe addr      din        en  dout      busy conf
    // T1 write then read
    vecs.push_back('{0, 0, 1, 16'h0001, 16'hABCD, 0, 16'h0000, 0, 0});
    vecs.push_back('{0, 1, 0, 16'h0001, 16'h0000, 0, 16'h0000, 1, 0});
    vecs.push_back('{0, 1, 0, 16'h0001, 16'h0000, 1, 16'hABCD, 1, 0});
    vecs.push_back('{0, 1, 1, 16'h0000, 16'h0000, 0, 16'hABCD, 1, 0});
    vecs.push_back('{0, 1, 1, 16'h0000, 16'h0000, 0, 16'hABCD, 0, 0});
    // T2 pipelined reads
    vecs.push_back('{0, 0, 1, 16'h0002, 16'h1111, 0, 16'hABCD, 0, 0});
    vecs.push_back('{0, 0, 1, 16'h0003, 16'h2222, 0, 16'hABCD, 0, 0});
    vecs.push_back('{0, 1, 0, 16'h0002, 16'h0000, 0, 16'hABCD, 1, 0});
    vecs.push_back('{0, 1, 0, 16'h0003, 16'h0000, 1, 16'h1111, 1, 0});
    vecs.push_back('{0, 1, 0, 16'h0003, 16'h0000, 1, 16'h2222, 1, 0});
    vecs.push_back('{0, 1, 1, 16'h0000, 16'h0000, 0, 16'h2222, 1, 0});
    vecs.push_back('{0, 1, 1, 16'h0000, 16'h0000, 0, 16'h2222, 0, 0});
    // T3 read before write
    vecs.push_back('{0, 0, 1, 16'h0005, 16'h00AA, 0, 16'h2222, 0, 0});
    vecs.push_back('{0, 1, 0, 16'h0005, 16'h0000, 0, 16'h2222, 1, 0});
    vecs.push_back('{0, 0, 1, 16'h0005, 16'hFFFF, 0, 16'h00AA, 1, 0});
    vecs.push_back('{0, 1, 1, 16'h0000, 16'h0000, 0, 16'h00AA, 0, 0});
    vecs.push_back('{0, 1, 0, 16'h0005, 16'h0000, 0, 16'h00AA, 1, 0});
    vecs.push_back('{0, 1, 0, 16'h0005, 16'h0000, 1, 16'hFFFF, 1, 0});
    vecs.push_back('{0, 1, 1, 16'h0000, 16'h0000, 0, 16'hFFFF, 1, 0});
    vecs.push_back('{0, 1, 1, 16'h0000, 16'h0000, 0, 16'hFFFF, 0, 0});
    // T4 conflict, single and back-to-back
    vecs.push_back('{0, 0, 0, 16'h0007, 16'h5A5A, 0, 16'hFFFF, 0, 1});
    vecs.push_back('{0, 1, 1, 16'h0000, 16'h0000, 0, 16'hFFFF, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0008, 16'h1234, 0, 16'hFFFF, 0, 1});
    vecs.push_back('{0, 0, 0, 16'h0008, 16'h4321, 0, 16'hFFFF, 0, 1});
    vecs.push_back('{0, 1, 1, 16'h0000, 16'h0000, 0, 16'hFFFF, 0, 0});
    vecs.push_back('{0, 1, 0, 16'h0007, 16'h0000, 0, 16'hFFFF, 1, 0});
    vecs.push_back('{0, 1, 0, 16'h0008, 16'h0000, 1, 16'h5A5A, 1, 0});
    // deselect flushes the read of addr 8, output word is held
    vecs.push_back('{1, 1, 1, 16'h0000, 16'h0000, 0, 16'h5A5A, 0, 0});
    vecs.push_back('{0, 1, 0, 16'h0008, 16'h0000, 0, 16'h5A5A, 1, 0});
    vecs.push_back('{0, 1, 0, 16'h0008, 16'h0000, 1, 16'h4321, 1, 0});
    vecs.push_back('{0, 1, 1, 16'h0000, 16'h0000, 0, 16'h4321, 1, 0});
    vecs.push_back('{0, 1, 1, 16'h0000, 16'h0000, 0, 16'h4321, 0, 0});

    reset_n   = 1'b0;
    sram_ce_n = 1'b1;
    sram_we_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_addr = 16'h0000;
    sram_din  = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk2("reset", 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("reset dout3", dout3, 16'h0000);
    chk("reset busy3", {15'd0, busy3}, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].ce_n, vecs[i].we_n, vecs[i].oe_n, vecs[i].addr, vecs[i].din);
      chk2($sformatf("v%0d", i), vecs[i].en, vecs[i].dout, vecs[i].busy, vecs[i].conf);
    end

    // T5 on the READ_LAT=3 device: read then deselect, nothing ever comes out
    step(0, 1, 0, 16'h0001, 16'h0000);
    chk("t5 issue busy3", {15'd0, busy3}, 16'h0001);
    chk("t5 issue en3",   {15'd0, en3},   16'h0000);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 16'h0000, 16'h0000);
      chk($sformatf("t5 flush%0d busy3", i), {15'd0, busy3}, 16'h0000);
      chk($sformatf("t5 flush%0d en3", i),   {15'd0, en3},   16'h0000);
      chk($sformatf("t5 flush%0d dout3", i), dout3,          16'h4321);
      $display("t5 flush%0d: busy3=%b en3=%b dout3=%h", i, busy3, en3, dout3);
    end
    // READ_LAT=3 latency: first read surfaces right after the third edge
    step(0, 1, 0, 16'h0001, 16'h0000);
    chk("t5 lat3 e1 en3", {15'd0, en3}, 16'h0000);
    step(0, 1, 0, 16'h0001, 16'h0000);
    chk("t5 lat3 e2 en3", {15'd0, en3}, 16'h0000);
    step(0, 1, 0, 16'h0001, 16'h0000);
    chk("t5 lat3 e3 en3",   {15'd0, en3}, 16'h0001);
    chk("t5 lat3 e3 dout3", dout3,        16'hABCD);
    $display("t5 lat3: en3=%b dout3=%h", en3, dout3);
    step(1, 1, 1, 16'h0000, 16'h0000);

    // T6 reset while reads and a conflict are live
    step(0, 1, 0, 16'h0002, 16'h0000);
    step(0, 1, 0, 16'h0002, 16'h0000);
    chk("t6 pre en2",   {15'd0, en2}, 16'h0001);
    chk("t6 pre dout2", dout2,        16'h1111);
    step(0, 0, 0, 16'h0009, 16'h0777);
    chk("t6 pre conf2", {15'd0, conf2}, 16'h0001);
    chk("t6 pre busy2", {15'd0, busy2}, 16'h0001);
    #1;
    reset_n = 1'b0;
    #1;
    chk2("t6 in reset", 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("t6 in reset dout3", dout3,          16'h0000);
    chk("t6 in reset busy3", {15'd0, busy3}, 16'h0000);
    chk("t6 in reset conf3", {15'd0, conf3}, 16'h0000);
    step(1, 1, 1, 16'h0000, 16'h0000);
    chk2("t6 held", 1'b0, 16'h0000, 1'b0, 1'b0);
    reset_n = 1'b1;
    step(0, 1, 0, 16'h0001, 16'h0000);
    chk2("t6 post r1", 1'b0, 16'h0000, 1'b1, 1'b0);
    step(0, 1, 0, 16'h0009, 16'h0000);
    chk2("t6 post r9", 1'b1, 16'hABCD, 1'b1, 1'b0);
    step(0, 1, 1, 16'h0000, 16'h0000);
    chk2("t6 post idle", 1'b0, 16'h0777, 1'b1, 1'b0);
    step(0, 1, 1, 16'h0000, 16'h0000);
    chk2("t6 drained", 1'b0, 16'h0777, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
